// File: rtl/vga_host_ctrl.sv
// Host-bus bridge between an asynchronous 8-bit host port and a 16-bit VRAM request interface.
// Optional interrupt support is compiled in with the VGA_HOST_IRQ_EN macro.
module vga_host_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int INC_STEP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nrd,
  input  logic              nwr,
  input  logic              ncs,
  input  logic [3:0]        ext_address,
  input  logic [7:0]        ext_data_in,
  output logic [7:0]        ext_data_out,
  output logic              int_req,
  input  logic              int_ack,
  output logic [1:0]        int_cmd,
  output logic [ADDR_W-1:0] int_address,
  output logic [15:0]       int_data_out,
  input  logic [15:0]       int_data_in,
  output logic              wait_sig,
  output logic              int_sig
);

  localparam int NB   = (ADDR_W + 7) / 8;
  localparam int PADW = NB * 8;
  localparam logic [1:0]        PTR_LAST = 2'(NB - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INC_STEP);
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_CLR  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, PEND = 2'd2} state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] rd_sync, wr_sync, cs_sync;
  logic                rd_prev, wr_prev;
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          ptr;
  logic [7:0]          def_col, last_col;
  logic                pend_vld;
  logic [1:0]          pend_cmd;
  logic [7:0]          pend_data;
  logic [1:0]          irq_en;
  logic                irq_pend;

  logic                rd_fall, wr_fall, acc, is_rd, clr_acc, req_acc, busy;
  logic [1:0]          acc_cmd;
  logic [PADW-1:0]     addr_pad, addr_ins;
  logic [7:0]          addr_byte, rd_byte;

  // strobe synchronisers plus one extra stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sync <= '1;
      wr_sync <= '1;
      cs_sync <= '1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], nrd};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], nwr};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], ncs};
      rd_prev <= rd_sync[SYNC_STAGES-1];
      wr_prev <= wr_sync[SYNC_STAGES-1];
    end
  end

  // access decode: exactly one strobe falling with chip select low
  always_comb begin
    rd_fall = rd_prev & ~rd_sync[SYNC_STAGES-1];
    wr_fall = wr_prev & ~wr_sync[SYNC_STAGES-1];
    acc     = (rd_fall ^ wr_fall) & ~cs_sync[SYNC_STAGES-1];
    is_rd   = rd_fall;
    busy    = (state != IDLE);
    clr_acc = acc && !is_rd && (ext_address == 4'd0) && (ext_data_in == 8'h80);
    req_acc = clr_acc || (acc && (ext_address == 4'd2));
    if (clr_acc) begin
      acc_cmd = CMD_CLR;
    end else if (is_rd) begin
      acc_cmd = CMD_RD;
    end else begin
      acc_cmd = CMD_WR;
    end
  end

  // byte-lane view of the address register and host readback mux
  always_comb begin
    addr_pad = '0;
    addr_pad[ADDR_W-1:0] = addr;
    addr_ins  = addr_pad;
    addr_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      addr_ins[i*8 +: 8] = (ptr == 2'(i)) ? ext_data_in : addr_pad[i*8 +: 8];
      addr_byte = (ptr == 2'(i)) ? addr_pad[i*8 +: 8] : addr_byte;
    end
    case (ext_address)
      4'd0:    rd_byte = {busy, irq_pend, 6'b000000};
      4'd1:    rd_byte = addr_byte;
      4'd3:    rd_byte = def_col;
      4'd4:    rd_byte = last_col;
      4'd5:    rd_byte = {6'b000000, irq_en};
      default: rd_byte = 8'h00;
    endcase
  end

  // register file, pending slot and request FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      int_req      <= 1'b0;
      int_cmd      <= CMD_NONE;
      int_address  <= '0;
      int_data_out <= 16'h0000;
      ext_data_out <= 8'h00;
      wait_sig     <= 1'b0;
      addr         <= '0;
      ptr          <= 2'd0;
      def_col      <= 8'h70;
      last_col     <= 8'h00;
      pend_vld     <= 1'b0;
      pend_cmd     <= CMD_NONE;
      pend_data    <= 8'h00;
    end else begin
      if (acc) begin
        if (ext_address == 4'd1) begin
          ptr <= (ptr == PTR_LAST) ? 2'd0 : ptr + 2'd1;
        end else begin
          ptr <= 2'd0;
        end
        if (is_rd) begin
          case (ext_address)
            4'd0, 4'd1, 4'd3, 4'd4, 4'd5: ext_data_out <= rd_byte;
            default: ;
          endcase
        end else begin
          case (ext_address)
            4'd1:    addr    <= addr_ins[ADDR_W-1:0];
            4'd3:    def_col <= ext_data_in;
            default: ;
          endcase
        end
      end
      // a memory access arriving while busy parks in the single pending slot
      if (req_acc && busy && !pend_vld) begin
        pend_vld  <= 1'b1;
        pend_cmd  <= acc_cmd;
        pend_data <= ext_data_in;
        wait_sig  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (req_acc) begin
            state        <= REQ;
            int_req      <= 1'b1;
            int_cmd      <= acc_cmd;
            int_address  <= clr_acc ? '0 : addr;
            int_data_out <= (acc_cmd == CMD_WR) ? {def_col, ext_data_in} : 16'h0000;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            int_cmd <= CMD_NONE;
            case (int_cmd)
              CMD_RD: begin
                ext_data_out <= int_data_in[7:0];
                last_col     <= int_data_in[15:8];
                addr         <= addr + STEP;
              end
              CMD_WR:  addr <= addr + STEP;
              CMD_CLR: addr <= '0;
              default: ;
            endcase
            state <= (pend_vld || req_acc) ? PEND : IDLE;
          end
        end
        PEND: begin
          state        <= REQ;
          int_req      <= 1'b1;
          int_cmd      <= pend_cmd;
          int_address  <= (pend_cmd == CMD_CLR) ? '0 : addr;
          int_data_out <= (pend_cmd == CMD_WR) ? {def_col, pend_data} : 16'h0000;
          pend_vld     <= 1'b0;
          wait_sig     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_HOST_IRQ_EN
  logic done_clr, done_dat, irq_wr;
  assign done_clr = (state == REQ) && int_ack && (int_cmd == CMD_CLR);
  assign done_dat = (state == REQ) && int_ack && ((int_cmd == CMD_RD) || (int_cmd == CMD_WR));
  assign irq_wr   = acc && !is_rd && (ext_address == 4'd5);

  // completion interrupts; a clear request from the host wins over a same-cycle event
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 2'b00;
      irq_pend <= 1'b0;
      int_sig  <= 1'b0;
    end else begin
      if ((done_clr && irq_en[0]) || (done_dat && irq_en[1])) begin
        irq_pend <= 1'b1;
        int_sig  <= 1'b1;
      end
      if (irq_wr) begin
        irq_en <= ext_data_in[1:0];
        if (ext_data_in[7]) begin
          irq_pend <= 1'b0;
          int_sig  <= 1'b0;
        end
      end
    end
  end
`else
  assign irq_en   = 2'b00;
  assign irq_pend = 1'b0;
  assign int_sig  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_host_ctrl.sv
// Directed bench for vga_host_ctrl: a transaction-level model of the host/VRAM behaviour is
// compared against the DUT on every falling clock edge, plus literal spot checks.
module tb_vga_host_ctrl;

  localparam int AW   = 16;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst, nrd, nwr, ncs, int_ack, int_req, wait_sig, int_sig;
  logic [3:0]    ext_address;
  logic [7:0]    ext_data_in, ext_data_out;
  logic [1:0]    int_cmd;
  logic [AW-1:0] int_address;
  logic [15:0]   int_data_out, int_data_in;

  vga_host_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SYNC), .INC_STEP(1)) dut (
    .clk(clk), .rst(rst), .nrd(nrd), .nwr(nwr), .ncs(ncs),
    .ext_address(ext_address), .ext_data_in(ext_data_in), .ext_data_out(ext_data_out),
    .int_req(int_req), .int_ack(int_ack), .int_cmd(int_cmd), .int_address(int_address),
    .int_data_out(int_data_out), .int_data_in(int_data_in),
    .wait_sig(wait_sig), .int_sig(int_sig)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  bit            chk_en = 1'b0;
  bit            cs_low = 1'b0;
  logic          exp_req, exp_wait;
  logic [1:0]    exp_cmd;
  logic [AW-1:0] exp_addr;
  logic [15:0]   exp_data;
  logic [7:0]    exp_dout;
  logic [AW-1:0] m_addr;
  int            m_ptr;
  logic [7:0]    m_def, m_last, m_pdata;
  logic          m_pv, m_irqpend;
  logic [1:0]    m_pcmd, m_irqen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_req = 1'b0; exp_cmd = 2'd0; exp_addr = '0; exp_data = 16'h0; exp_wait = 1'b0;
    exp_dout = 8'h00; m_addr = '0; m_ptr = 0; m_def = 8'h70; m_last = 8'h00;
    m_pv = 1'b0; m_pcmd = 2'd0; m_pdata = 8'h00; m_irqen = 2'b00; m_irqpend = 1'b0;
  endtask

  task automatic start(input logic [1:0] cmd, input logic [7:0] d);
    if (!exp_req) begin
      exp_req = 1'b1; exp_cmd = cmd;
      exp_addr = (cmd == 2'd3) ? '0 : m_addr;
      exp_data = {m_def, d};
    end else if (!m_pv) begin
      m_pv = 1'b1; m_pcmd = cmd; m_pdata = d; exp_wait = 1'b1;
    end
  endtask

  task automatic model_decode(input bit rd, input logic [3:0] a, input logic [7:0] d);
    if (rd) begin
      case (a)
        4'd0: exp_dout = {exp_req, m_irqpend, 6'b000000};
        4'd1: exp_dout = m_addr[m_ptr*8 +: 8];
        4'd2: start(2'd1, d);
        4'd3: exp_dout = m_def;
        4'd4: exp_dout = m_last;
        4'd5: exp_dout = {6'b000000, m_irqen};
        default: ;
      endcase
    end else begin
      case (a)
        4'd0: if (d == 8'h80) start(2'd3, d);
        4'd1: m_addr[m_ptr*8 +: 8] = d;
        4'd2: start(2'd2, d);
        4'd3: m_def = d;
`ifdef VGA_HOST_IRQ_EN
        4'd5: begin
          m_irqen = d[1:0];
          if (d[7]) m_irqpend = 1'b0;
        end
`endif
        default: ;
      endcase
    end
    m_ptr = (a == 4'd1) ? (m_ptr + 1) % 2 : 0;
  endtask

  // one host strobe; the DUT reacts SYNC+1 edges after the strobe falls
  task automatic host(input bit rd, input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ext_address = a; ext_data_in = d;
    if (rd) nrd = 1'b0; else nwr = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    if (cs_low) model_decode(rd, a, d);
    #1 nrd = 1'b1; nwr = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #2;
  endtask

  task automatic ack(input logic [15:0] rdata);
    bit was;
    @(posedge clk); #1 int_ack = 1'b1; int_data_in = rdata;
    @(posedge clk);
    was = exp_req;
    if (was) begin
      case (exp_cmd)
        2'd1: begin exp_dout = rdata[7:0]; m_last = rdata[15:8]; m_addr = m_addr + 1'b1; end
        2'd2: m_addr = m_addr + 1'b1;
        2'd3: m_addr = '0;
        default: ;
      endcase
`ifdef VGA_HOST_IRQ_EN
      if ((exp_cmd == 2'd3 && m_irqen[0]) || (exp_cmd != 2'd3 && m_irqen[1])) m_irqpend = 1'b1;
`endif
      exp_req = 1'b0; exp_cmd = 2'd0;
    end
    #1 int_ack = 1'b0;
    if (was && m_pv) begin
      @(posedge clk);
      m_pv = 1'b0; exp_wait = 1'b0; exp_req = 1'b1; exp_cmd = m_pcmd;
      exp_addr = (m_pcmd == 2'd3) ? '0 : m_addr;
      exp_data = {m_def, m_pdata};
    end
    #2;
  endtask

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("int_req", int_req, exp_req);
      check("int_cmd", int_cmd, exp_cmd);
      check("wait_sig", wait_sig, exp_wait);
      check("ext_data_out", ext_data_out, exp_dout);
      check("int_sig", int_sig, m_irqpend);
      if (exp_req) check("int_address", int_address, exp_addr);
      if (exp_req && exp_cmd == 2'd2) check("int_data_out", int_data_out, exp_data);
    end
  end

  initial begin
    rst = 1'b1; nrd = 1'b1; nwr = 1'b1; ncs = 1'b1; int_ack = 1'b0; int_data_in = 16'h0;
    ext_address = 4'd0; ext_data_in = 8'h00;
    model_reset();
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_int_address", int_address, 16'h0000);
    check("rst_int_data_out", int_data_out, 16'h0000);
    rst = 1'b0; ncs = 1'b0; cs_low = 1'b1;
    repeat (4) @(posedge clk);

    host(1'b1, 4'd3, 8'h00); check("rst_def_col", ext_data_out, 8'h70);
    host(1'b1, 4'd4, 8'h00); check("rst_last_col", ext_data_out, 8'h00);
    host(1'b1, 4'd0, 8'h00); check("rst_status", ext_data_out, 8'h00);
    host(1'b1, 4'd5, 8'h00); check("rst_irq_ctl", ext_data_out, 8'h00);

    // byte-wise address access
    host(1'b0, 4'd1, 8'h34); host(1'b0, 4'd1, 8'h12);
    host(1'b1, 4'd1, 8'h00); check("addr_lo", ext_data_out, 8'h34);
    host(1'b1, 4'd1, 8'h00); check("addr_hi", ext_data_out, 8'h12);
    // another register in between restarts at the low byte
    host(1'b0, 4'd1, 8'hAB); host(1'b1, 4'd3, 8'h00);
    host(1'b0, 4'd1, 8'h10); host(1'b0, 4'd1, 8'h00);
    check("model_addr_0010", m_addr, 16'h0010);

    // data-port write
    host(1'b0, 4'd2, 8'h41);
    check("wr_cmd", int_cmd, 2'd2);
    check("wr_addr", int_address, 16'h0010);
    check("wr_data", int_data_out, 16'h7041);
    repeat (3) @(posedge clk);
    ack(16'h0000);
    host(1'b1, 4'd1, 8'h00); check("addr_after_wr_lo", ext_data_out, 8'h11);
    host(1'b1, 4'd1, 8'h00); check("addr_after_wr_hi", ext_data_out, 8'h00);

    // data-port read with wrap
    host(1'b0, 4'd1, 8'hFF); host(1'b0, 4'd1, 8'hFF);
    host(1'b1, 4'd2, 8'h00);
    check("rd_cmd", int_cmd, 2'd1);
    check("rd_addr", int_address, 16'hFFFF);
    ack(16'h1E58);
    check("rd_data", ext_data_out, 8'h58);
    host(1'b1, 4'd4, 8'h00); check("last_col", ext_data_out, 8'h1E);
    host(1'b1, 4'd1, 8'h00); check("wrap_lo", ext_data_out, 8'h00);
    host(1'b1, 4'd1, 8'h00); check("wrap_hi", ext_data_out, 8'h00);

    // clear with a queued write; further busy accesses dropped
    host(1'b0, 4'd1, 8'h34); host(1'b0, 4'd1, 8'h12);
    host(1'b0, 4'd0, 8'h80);
    check("clr_cmd", int_cmd, 2'd3);
    check("clr_addr", int_address, 16'h0000);
    host(1'b1, 4'd0, 8'h00); check("status_busy", ext_data_out, 8'h80);
    host(1'b0, 4'd2, 8'h20); check("wait_raised", wait_sig, 1'b1);
    host(1'b0, 4'd2, 8'h55);
    host(1'b0, 4'd0, 8'h80);
    ack(16'h0000);
    check("queued_cmd", int_cmd, 2'd2);
    check("queued_addr", int_address, 16'h0000);
    check("queued_data", int_data_out, 16'h7020);
    check("wait_dropped", wait_sig, 1'b0);
    ack(16'h0000);
    repeat (5) @(posedge clk);
    check("no_dropped_req", int_req, 1'b0);
    host(1'b1, 4'd1, 8'h00); check("addr_after_q", ext_data_out, 8'h01);
    host(1'b1, 4'd1, 8'h00);

    // ignored: unknown command, stray ack, ncs high, simultaneous strobes
    host(1'b0, 4'd0, 8'h01);
    ack(16'hFFFF);
    check("stray_ack", ext_data_out, 8'h00);
    #1 ncs = 1'b1; cs_low = 1'b0;
    repeat (4) @(posedge clk);
    host(1'b0, 4'd2, 8'h77); host(1'b0, 4'd3, 8'h99);
    #1 ncs = 1'b0; cs_low = 1'b1;
    repeat (4) @(posedge clk);
    @(posedge clk); #1 ext_address = 4'd2; nrd = 1'b0; nwr = 1'b0;
    repeat (2 * (SYNC + 1)) @(posedge clk);
    #1 nrd = 1'b1; nwr = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #2 check("both_strobes", int_req, 1'b0);

    // new default colour
    host(1'b0, 4'd3, 8'h1F);
    host(1'b0, 4'd2, 8'hAA);
    check("colour_data", int_data_out, 16'h1FAA);
    ack(16'h0000);

`ifdef VGA_HOST_IRQ_EN
    host(1'b0, 4'd5, 8'h01);
    host(1'b0, 4'd0, 8'h80);
    ack(16'h0000);
    check("irq_set", int_sig, 1'b1);
    host(1'b1, 4'd0, 8'h00); check("status_irq", ext_data_out, 8'h40);
    host(1'b0, 4'd5, 8'h80); check("irq_clr", int_sig, 1'b0);
    host(1'b0, 4'd5, 8'h02);
    host(1'b0, 4'd2, 8'h11);
    ack(16'h0000);
    check("irq_data", int_sig, 1'b1);
    host(1'b0, 4'd5, 8'h80);
`else
    host(1'b0, 4'd5, 8'h03);
    host(1'b1, 4'd5, 8'h00); check("irq_ctl_absent", ext_data_out, 8'h00);
    host(1'b0, 4'd0, 8'h80);
    ack(16'h0000);
    check("no_int_sig", int_sig, 1'b0);
    host(1'b1, 4'd0, 8'h00); check("status_no_irq", ext_data_out, 8'h00);
`endif

    // reset in the middle of a request with a queued access
    host(1'b0, 4'd1, 8'h00); host(1'b0, 4'd1, 8'h00);
    host(1'b0, 4'd2, 8'h33);
    host(1'b0, 4'd2, 8'h44);
    check("pre_rst_wait", wait_sig, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); model_reset();
    #1 rst = 1'b0;
    ack(16'h5555);
    check("rst_req", int_req, 1'b0);
    check("rst_wait", wait_sig, 1'b0);
    repeat (4) @(posedge clk);
    host(1'b1, 4'd1, 8'h00); check("rst_addr_lo", ext_data_out, 8'h00);
    host(1'b1, 4'd1, 8'h00); check("rst_addr_hi", ext_data_out, 8'h00);
    host(1'b1, 4'd3, 8'h00); check("rst_def_col2", ext_data_out, 8'h70);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_host_ctrl.md
VGA_HOST_CTRL -- requirements
Module: vga_host_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: VRAM address width, range 8..24.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on nrd/nwr/ncs, minimum 2.
REQ-003 SHALL have parameter INC_STEP, default 1: VRAM address increment after each data-port access.
REQ-004 SHALL have ports: clk  in  1  system clock; one clock domain, all logic on posedge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 nrd, nwr, ncs  in  1 each  asynchronous host strobes, active-low.
REQ-007 ext_address  in  4  host register select; ext_data_in  in  8  host write data.
REQ-008 ext_data_out  out  8  host read data.
REQ-009 int_req  out  1  memory request; int_ack  in  1  one-cycle completion pulse.
REQ-010 int_cmd  out  2  request type: 1 = read, 2 = write, 3 = clear; 0 = none.
REQ-011 int_address  out  ADDR_W  request address; int_data_out  out  16  write word {colour, char}; int_data_in  in  16  read word.
REQ-012 wait_sig  out  1  host wait; int_sig  out  1  host interrupt.

Function
REQ-013 SHALL synchronise nrd/nwr/ncs through SYNC_STAGES flops and decode a host access on the first cycle a synchronised strobe is seen falling while synchronised ncs=0.
REQ-014 SHALL ignore accesses where nrd and nwr fall in the same cycle, and all strobes while ncs=1.
REQ-015 Register map: 0 R status {busy, irq_pend, 6'b0} / W command; 1 address bytes; 2 data port; 3 default colour; 4 last colour (R); 5 irq control.
REQ-016 SHALL load ext_data_out the cycle after decode for registers 0, 1, 3, 4, 5.
REQ-017 Address register SHALL be accessed byte-wise, LSB first, through a byte pointer that counts 0..ceil(ADDR_W/8)-1 and then wraps; bits above ADDR_W are written as don't-care and read as 0.
REQ-018 Any access to a register other than 1 SHALL reset the byte pointer to 0.
REQ-019 FSM states: IDLE, REQ, PEND. IDLE->REQ on a data-port access or a command write of 8'h80. REQ holds int_req=1 with stable int_cmd/int_address/int_data_out until int_ack; then ->IDLE, or ->PEND if an access is queued.
REQ-020 Data-port write SHALL issue int_cmd=2, int_data_out={default colour, ext_data_in}.
REQ-021 Data-port read SHALL issue int_cmd=1. On int_ack, ext_data_out <= int_data_in[7:0] and last colour <= int_data_in[15:8].
REQ-022 Command 8'h80 SHALL issue int_cmd=3 with int_address=0. On ack, the address register SHALL clear to 0. Other command values SHALL be ignored.
REQ-023 On ack of a read or write, the address SHALL advance by INC_STEP modulo 2^ADDR_W; wrap from all-ones to 0 is required.
REQ-024 int_req SHALL assert the cycle after decode; the minimum access-to-ack path is SYNC_STAGES+2 cycles.
REQ-025 An access to the data port or command register while busy SHALL be latched into one pending slot, raise wait_sig the next cycle, and hold it.
REQ-026 PEND SHALL issue the latched access the cycle after the previous ack; wait_sig SHALL drop the cycle that access's int_req asserts.
REQ-027 A further busy access while the pending slot is full SHALL be dropped.
REQ-028 Accesses to registers 1, 3, 4 and 5 SHALL complete immediately even while busy.
REQ-029 int_ack outside state REQ SHALL be ignored.

Reset
REQ-030 On rst, the following SHALL hold the next cycle: FSM IDLE, int_req=0, int_cmd=0, int_address=0, int_data_out=0, ext_data_out=0, wait_sig=0, int_sig=0, address=0, byte pointer=0, default colour=8'h70, last colour=0, pending slot empty.
REQ-031 rst asserted mid-request SHALL abandon the request without any address update; a late int_ack SHALL be ignored.

Configuration
REQ-032 Macro VGA_HOST_IRQ_EN: when defined, register 5 bit0 = clear-done IRQ enable and bit1 = data-done IRQ enable. A completing request of an enabled kind SHALL set irq_pend and int_sig. Writing register 5 with bit7=1 SHALL clear both.
REQ-033 Without VGA_HOST_IRQ_EN: int_sig is constant 0, register 5 reads 0 and ignores writes, and status irq_pend reads 0.

Verification
REQ-034 Write register 1 with 8'h34 then 8'h12, then read register 1 twice -> reads return 8'h34, 8'h12.
REQ-035 Address 16'h0010, default colour 8'h70, write 8'h41 to the data port -> int_cmd=2, int_address=16'h0010, int_data_out=16'h7041 until ack; address becomes 16'h0011.
REQ-036 Address 16'hFFFF, read the data port, memory returns 16'h1E58 -> ext_data_out=8'h58, register 4 reads 8'h1E, address wraps to 16'h0000.
REQ-037 Write command 8'h80, then write 8'h20 to the data port before ack -> wait_sig=1; after ack, a write issues at address 0 and wait_sig falls.
REQ-038 With VGA_HOST_IRQ_EN defined and register 5 set to 8'h01, issue a clear and ack -> int_sig=1 and status reads 8'h40; write 8'h80 to register 5 -> int_sig=0.
REQ-039 Assert rst during state REQ, then pulse int_ack -> int_req=0, address unchanged at 0, wait_sig=0.
